// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
//   state_e        : transaction FSM states
//   SZ_*           : access size encodings carried on req_size
//   is_misaligned  : 1 when a size/offset pair cannot be issued as one access
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Illegal size counts as misaligned so the FSM has a single error check.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between the core and a 32-bit word port.
// Ports:
//   size_i, off_i, signed_i : access size, byte offset addr[1:0], sign-extend flag
//   wdata_i / wdata_o       : right-justified store data / data shifted into its lanes
//   wstrb_o                 : byte strobes for the addressed lanes
//   rdata_i / rdata_o       : raw memory word / extracted and extended load value
//   misaligned_o            : access cannot be performed (includes illegal size)
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [4:0]  shamt;
    logic [31:0] raw;

    assign shamt        = {off_i, 3'b000};
    assign wdata_o      = wdata_i << shamt;
    assign raw          = rdata_i >> shamt;
    assign misaligned_o = is_misaligned(size_i, off_i);

    always_comb begin
        wstrb_o = 4'b0000;
        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                wstrb_o = 4'b0001 << off_i;
                rdata_o = {{24{signed_i & raw[7]}}, raw[7:0]};
            end
            SZ_HALF: begin
                wstrb_o = 4'b0011 << off_i;
                rdata_o = {{16{signed_i & raw[15]}}, raw[15:0]};
            end
            SZ_WORD: begin
                wstrb_o = 4'b1111;
                rdata_o = raw;
            end
            default: begin
                wstrb_o = 4'b0000;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one byte/half/word access from the core, issues
// a word-aligned valid/ready request to data memory, waits for read data and
// returns a one-cycle response. One transaction in flight; optional timeout.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   req_*_i / req_ready_o         : core access request channel
//   resp_valid_o/rdata_o/err_o    : one-cycle completion pulse with result
//   mem_req_valid_o/mem_req_ready_i, mem_we_o, mem_addr_o, mem_wdata_o,
//   mem_wstrb_o                   : memory request channel
//   mem_rvalid_i, mem_rdata_i     : memory read return
// Parameter TIMEOUT: cycles allowed in REQ+WAIT before abort (0 = never).
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_signed_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned     CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic          signed_q, signed_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          idle;
    logic          in_req;
    logic          timeout_hit;

    logic [1:0]    lane_size;
    logic [1:0]    lane_off;
    logic          lane_signed;
    logic [3:0]    lane_wstrb;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;
    logic          lane_misaligned;

    assign idle        = (state_q == IDLE);
    assign in_req      = (state_q == REQ);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // One lane aligner serves both directions: in IDLE it sees the incoming
    // request (strobes, store shift, alignment); afterwards it sees the
    // captured access so the load path can extract from mem_rdata_i.
    assign lane_size   = idle ? req_size_i         : size_q;
    assign lane_off    = idle ? req_addr_i[1:0]    : off_q;
    assign lane_signed = idle ? req_signed_i       : signed_q;

    lsu_lane_align u_lane (
        .size_i       (lane_size),
        .off_i        (lane_off),
        .signed_i     (lane_signed),
        .wdata_i      (req_wdata_i),
        .rdata_i      (mem_rdata_i),
        .wstrb_o      (lane_wstrb),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_misaligned)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        signed_d = signed_q;
        size_d   = size_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_write_i;
                    signed_d = req_signed_i;
                    size_d   = req_size_i;
                    off_d    = req_addr_i[1:0];
                    addr_d   = req_addr_i[31:2];
                    wdata_d  = lane_wdata;
                    wstrb_d  = req_write_i ? lane_wstrb : 4'b0000;
                    cnt_d    = '0;
                    rdata_d  = 32'h0;
                    if (lane_misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A handshake on the last allowed cycle still wins over abort.
                if (mem_req_ready_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (we_q) begin
                        err_d   = 1'b0;
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    err_d   = 1'b0;
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            addr_q   <= 30'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'b0000;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // req_ready is qualified by reset so it reads 0 while reset is held.
    assign req_ready_o     = rst_ni & idle;

    // Memory-side fields are only presented while the request is outstanding.
    assign mem_req_valid_o = in_req;
    assign mem_we_o        = in_req & we_q;
    assign mem_addr_o      = in_req ? {addr_q, 2'b00} : 32'h0;
    assign mem_wdata_o     = in_req ? wdata_q : 32'h0;
    assign mem_wstrb_o     = in_req ? wstrb_q : 4'b0000;

    assign resp_valid_o    = (state_q == RESP);
    assign resp_rdata_o    = resp_valid_o ? rdata_q : 32'h0;
    assign resp_err_o      = resp_valid_o & err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_t;
    logic        req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, resp_valid, resp_err, mem_req_valid, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        req_ready_t, resp_valid_t, resp_err_t, mem_req_valid_t, mem_we_t;
    logic [31:0] resp_rdata_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_wstrb_t;

    int vectors = 0;
    int miscompares = 0;
    int txn = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.TIMEOUT(255)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_signed_i(req_signed),
        .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu_mem_initiator #(.TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_t), .req_ready_o(req_ready_t),
        .req_write_i(req_write), .req_signed_i(req_signed),
        .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_t), .resp_rdata_o(resp_rdata_t), .resp_err_o(resp_err_t),
        .mem_req_valid_o(mem_req_valid_t), .mem_req_ready_i(mem_req_ready),
        .mem_we_o(mem_we_t), .mem_addr_o(mem_addr_t), .mem_wdata_o(mem_wdata_t),
        .mem_wstrb_o(mem_wstrb_t), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic        ill;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        sg;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy;
        int          rv;
        logic        e_ill;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    // Reference model: plain arithmetic on byte counts and masks.
    function automatic exp_t model(input logic wr, input logic sg, input logic [1:0] sz,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
        exp_t  e;
        int    nb;
        int    off;
        logic [63:0] mask, val;
        nb  = (sz == 2'd3) ? 0 : (1 << sz);
        off = int'(addr % 4);
        e.ill   = (nb == 0) || ((off % nb) != 0);
        e.addr  = addr - 32'(off);
        e.strb  = (wr && !e.ill) ? 4'(((1 << nb) - 1) << off) : 4'b0;
        e.wdata = wdata << (8 * off);
        e.err   = e.ill;
        e.rdata = 32'h0;
        if (!wr && !e.ill) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            val  = ({32'h0, rdata} >> (8 * off)) & mask;
            if (sg && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
            e.rdata = val[31:0];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic do_access(input string tag, input vec_t v);
        logic stable;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_signed = v.sg; req_size = v.sz;
        req_addr = v.addr; req_wdata = v.wdata; mem_req_ready = 1'b0;
        step();
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        if (!v.e_ill) begin
            check({tag, ".memvalid"}, 32'(mem_req_valid), 32'd1);
            check({tag, ".addr"}, mem_addr, v.e_addr);
            check({tag, ".strb"}, 32'(mem_wstrb), 32'(v.e_strb));
            check({tag, ".we"}, 32'(mem_we), 32'(v.wr));
            if (v.wr) check({tag, ".wdata"}, mem_wdata, v.e_wdata);
            stable = 1'b1;
            for (int k = 0; k < v.rdy; k++) begin
                step();
                if (!(mem_req_valid && mem_addr == v.e_addr && mem_wstrb == v.e_strb &&
                      mem_we == v.wr && (!v.wr || mem_wdata == v.e_wdata) && !resp_valid))
                    stable = 1'b0;
            end
            check({tag, ".stable"}, 32'(stable), 32'd1);
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            if (!v.wr) begin
                check({tag, ".wait"}, {30'b0, mem_req_valid, resp_valid}, 32'd0);
                for (int k = 0; k < v.rv; k++) step();
                mem_rvalid = 1'b1; mem_rdata = v.rdata;
                step();
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
        end else begin
            check({tag, ".nomem"}, 32'(mem_req_valid), 32'd0);
        end
        check({tag, ".resp"}, 32'(resp_valid), 32'd1);
        check({tag, ".rdata"}, resp_rdata, v.e_rdata);
        check({tag, ".err"}, 32'(resp_err), 32'(v.e_err));
        $display("txn %0d %s: we=%0d sz=%0d sg=%0d addr=%08h -> rdata=%08h err=%0d",
                 txn, tag, v.wr, v.sz, v.sg, v.addr, resp_rdata, resp_err);
        txn++;
        step();
        check({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        int   cycles;

        vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h80000003, 32'h000000AB, 32'h0, 0, 0,
                    1'b0, 32'h80000000, 4'b1000, 32'hAB000000, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 32'h80000002, 32'h0, 32'h8001FFFF, 0, 0,
                    1'b0, 32'h80000000, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2'b01, 32'h80000002, 32'h0, 32'h8001FFFF, 0, 0,
                    1'b0, 32'h80000000, 4'b0000, 32'h0, 32'h00008001, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 2'b10, 32'h80000006, 32'h0, 32'h0, 0, 0,
                    1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 2'b11, 32'h80000000, 32'h0, 32'h0, 0, 0,
                    1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'b01, 32'h80000002, 32'h00001234, 32'h0, 5, 0,
                    1'b0, 32'h80000000, 4'b1100, 32'h12340000, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 2'b00, 32'h80000001, 32'h0, 32'h00008000, 0, 0,
                    1'b0, 32'h80000000, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 2'b10, 32'h80000004, 32'h0, 32'hDEADBEEF, 0, 0,
                    1'b0, 32'h80000004, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 2'b01, 32'h80000001, 32'h0000BEEF, 32'h0, 0, 0,
                    1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 2'b10, 32'h00001000, 32'hCAFEF00D, 32'h0, 2, 0,
                    1'b0, 32'h00001000, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_valid_t = 1'b0; req_write = 1'b0;
        req_signed = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        repeat (3) step();
        check("reset.ctl", {21'b0, req_ready, mem_req_valid, mem_we, mem_wstrb,
                            resp_valid, resp_err, 4'b0}, 32'd0);
        check("reset.data", mem_addr | mem_wdata | resp_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset.release_ready", 32'(req_ready), 32'd1);
        step();

        // Stray read data while idle must not produce a response.
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        check("stray.resp", {31'b0, resp_valid}, 32'd0);
        check("stray.ready", 32'(req_ready), 32'd1);

        // Table vectors, issued back to back.
        for (int i = 0; i < 10; i++) do_access($sformatf("tbl%0d", i), vecs[i]);

        // Timeout after 4 REQ cycles on the TIMEOUT=4 instance.
        check("to.ready", 32'(req_ready_t), 32'd1);
        req_valid_t = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_addr = 32'h80000000; mem_req_ready = 1'b0;
        step();
        req_valid_t = 1'b0;
        cycles = 0;
        for (int k = 0; k < 20 && mem_req_valid_t; k++) begin
            cycles++;
            step();
        end
        check("to.req_cycles", 32'(cycles), 32'd4);
        check("to.resp", 32'(resp_valid_t), 32'd1);
        check("to.err", 32'(resp_err_t), 32'd1);
        check("to.rdata", resp_rdata_t, 32'd0);
        step();
        check("to.pulse", {31'b0, resp_valid_t}, 32'd0);
        $display("txn %0d timeout: req_cycles=%0d", txn, cycles);
        txn++;

        // Reset while waiting for read data abandons the transaction.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h80000010;
        step();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("rstwait.inwait", {31'b0, mem_req_valid | resp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstwait.ctl", {21'b0, req_ready, mem_req_valid, mem_we, mem_wstrb,
                              resp_valid, resp_err, 4'b0}, 32'd0);
        check("rstwait.data", mem_addr | mem_wdata | resp_rdata, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_rvalid = 1'b0;
        check("rstwait.noresp", {31'b0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rstwait.ready", 32'(req_ready), 32'd1);
        step();
        check("rstwait.noresp2", {31'b0, resp_valid}, 32'd0);
        v = '{1'b0, 1'b1, 2'b00, 32'h80000002, 32'h0, 32'h00800000, 0, 1,
              1'b0, 32'h80000000, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0};
        do_access("postrst", v);

        // Randomized accesses checked against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.sg    = 1'($urandom_range(0, 1));
            v.sz    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr = v.addr & ~((32'd1 << v.sz) - 32'd1);
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rdy   = $urandom_range(0, 3);
            v.rv    = $urandom_range(0, 2);
            if (v.wr == 1'b0 || v.sz != 2'b10) v.wdata = v.wdata & ((v.sz == 2'b00) ? 32'hFF : 32'hFFFF);
            e = model(v.wr, v.sg, v.sz, v.addr, v.wdata, v.rdata);
            v.e_ill = e.ill; v.e_addr = e.addr; v.e_strb = e.strb;
            v.e_wdata = e.wdata; v.e_rdata = e.rdata; v.e_err = e.err;
            do_access($sformatf("rnd%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator. Sits between the core's execute/memory stage and a word-organised data memory port.
- Accepts one byte, half or word access from the core. Checks alignment, then drives a word-aligned valid/ready request with byte strobes and lane-shifted write data.
- Waits for read data, extracts and sign/zero-extends the addressed lane, and returns a single-cycle response.
- Single outstanding transaction, with a timeout abort.

Parameters:
- TIMEOUT, 255: cycles allowed in REQ+WAIT before abort with error. 0 disables the timeout.
- Data and address width are fixed at 32.

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- req_valid  in  1  core access request
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1=store, 0=load
- req_signed  in  1  sign-extend load result
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or timeout
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write request
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte strobes; 0000 on reads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  raw word read data

Behaviour:
- Reset:
  - While reset=0: state=IDLE, timeout counter=0, every output 0, including req_ready.
  - After reset=1: req_ready=1.
  - Reset mid-transaction abandons it. No response is produced.
- States: IDLE, REQ, WAIT, RESP. req_ready = (state==IDLE).
- IDLE:
  - On req_valid&&req_ready, register write, signed, size, addr[1:0], aligned addr, shifted wdata and strobe.
  - Illegal if size==11, or size==01 with addr[0]=1, or size==10 with addr[1:0]!=0.
  - Illegal → RESP with err=1. Legal → REQ.
- REQ:
  - mem_req_valid=1; mem_we, mem_addr, mem_wdata and mem_wstrb hold stable until handshake.
  - Handshake with write → RESP, err=0. Handshake with read → WAIT.
- WAIT:
  - On mem_rvalid, capture the extracted result → RESP.
  - mem_rvalid seen in any other state is ignored.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 and no handshake/rvalid that cycle → RESP with err=1, rdata=0. mem_req_valid drops (abort).
- RESP:
  - resp_valid=1 for exactly one cycle. No backpressure. Next state IDLE.
  - resp_rdata and resp_err are registered, valid only with resp_valid, 0 otherwise.
- Latency:
  - Store with mem_req_ready=1: accept cycle N, REQ N+1, resp_valid N+2.
  - Load with rvalid one cycle after handshake: resp_valid N+3.
  - Back-to-back issue: new request accepted the cycle after RESP.
- Lane rules (off = addr[1:0]):
  - wstrb: byte = 0001<<off; half = 0011<<off; word = 1111.
  - mem_wdata = req_wdata << (8*off).
  - Load: raw = mem_rdata >> (8*off).
    - byte: raw[7:0], extended with raw[7] if signed, else zeros.
    - half: raw[15:0], extended with raw[15] if signed, else zeros.
    - word: raw unchanged; signed is ignored.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, REQ, WAIT, RESP)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - alignment-check function
- Sub-module lsu_lane_align (purely combinational):
  - inputs size, off, signed, wdata, rdata
  - outputs wstrb, shifted wdata, extended rdata, misaligned
- Top module holds the FSM, timeout counter and registers.

Test Plan:
- Store byte, addr 0x80000003, wdata 0x000000AB, mem_req_ready=1 → mem_addr 0x80000000, wstrb 1000, wdata 0xAB000000; resp_valid 2 cycles after accept, err=0.
- Load half signed, addr 0x80000002, mem_rdata 0x8001FFFF one cycle after handshake → resp_rdata 0xFFFF8001. Same access unsigned → 0x00008001.
- Load word, addr 0x80000006 → no mem_req_valid ever; resp_valid the cycle after accept with err=1, rdata=0. size=11 at an aligned address gives the same response.
- mem_req_ready held 0 for 5 cycles with TIMEOUT=255 → request fields stable throughout; completes normally after ready. With TIMEOUT=4 and ready never → err=1 after 4 REQ cycles.
- Stray mem_rvalid while IDLE is ignored. Reset asserted while in WAIT → outputs 0 immediately, no resp_valid; next request after release behaves normally.
- Back-to-back loads, byte signed at off 1 then word → second accepted the cycle after first resp. Results 0xFFFFFF80 for rdata 0x00008000, and the full word respectively.
